// File: rtl/painterengine_gpu_frame_streamer.sv
// Frame-fetch sequencer: walks a clipped viewport row by row and issues bounded DMA read bursts.
// Launch-to-first-request is 3 cycles; each burst waits in WAIT until the pixel FIFO can absorb it.
module painterengine_gpu_frame_streamer #(
   parameter int ADDR_WIDTH       = 32,
   parameter int DIM_WIDTH        = 16,
   parameter int BYTES_PER_PIXEL  = 4,
   parameter int BURST_MAX        = 64,
   parameter int FIFO_COUNT_WIDTH = 8
) (
   input  logic                        i_wire_clock,
   input  logic                        i_wire_reset,
   input  logic                        i_wire_start,
   input  logic                        i_wire_abort,
   input  logic                        i_wire_continuous,
   input  logic                        i_wire_frame_sync,
   input  logic [ADDR_WIDTH-1:0]       i_wire_image_address,
   input  logic [DIM_WIDTH-1:0]        i_wire_image_stride,
   input  logic [DIM_WIDTH-1:0]        i_wire_view_x,
   input  logic [DIM_WIDTH-1:0]        i_wire_view_y,
   input  logic [DIM_WIDTH-1:0]        i_wire_clip_width,
   input  logic [DIM_WIDTH-1:0]        i_wire_clip_height,
   input  logic [FIFO_COUNT_WIDTH-1:0] i_wire_fifo_free_count,
   output logic [ADDR_WIDTH-1:0]       o_wire_reader_address,
   output logic [DIM_WIDTH-1:0]        o_wire_reader_length,
   output logic                        o_wire_reader_start,
   input  logic                        i_wire_reader_done,
   input  logic                        i_wire_reader_error,
   output logic                        o_wire_busy,
   output logic                        o_wire_frame_done,
   output logic                        o_wire_error,
   output logic [2:0]                  o_wire_state,
   output logic [DIM_WIDTH-1:0]        o_wire_row,
   output logic [15:0]                 o_wire_frame_count
);

   localparam int CW = (FIFO_COUNT_WIDTH > DIM_WIDTH) ? FIFO_COUNT_WIDTH : DIM_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CALC   = 3'd1,
      S_WAIT   = 3'd2,
      S_ISSUE  = 3'd3,
      S_STREAM = 3'd4,
      S_NEXT   = 3'd5,
      S_DONE   = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [DIM_WIDTH-1:0]  stride_q, vx_q, vy_q, cw_q, ch_q;
   logic [DIM_WIDTH-1:0]  row_q, row_d, col_q, col_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DIM_WIDTH-1:0]  len_q, len_d;
   logic                  error_q, error_d;
   logic                  frame_done_q;
   logic [15:0]           frame_count_q;
   logic                  latch_cfg;
   logic                  launch;
   logic                  done_entry;

   logic [ADDR_WIDTH-1:0] pix_index;
   logic [ADDR_WIDTH-1:0] calc_addr;
   logic [DIM_WIDTH-1:0]  remaining;
   logic [DIM_WIDTH-1:0]  calc_len;
   logic [DIM_WIDTH-1:0]  col_sum;
   logic [DIM_WIDTH-1:0]  row_inc;

   // All address arithmetic is done at ADDR_WIDTH so the result wraps modulo 2^ADDR_WIDTH.
   always_comb begin
      pix_index = (ADDR_WIDTH'(vy_q) + ADDR_WIDTH'(row_q)) * ADDR_WIDTH'(stride_q)
                + ADDR_WIDTH'(vx_q) + ADDR_WIDTH'(col_q);
      calc_addr = base_q + pix_index * ADDR_WIDTH'(BYTES_PER_PIXEL);
      remaining = cw_q - col_q;
      calc_len  = (remaining > DIM_WIDTH'(BURST_MAX)) ? DIM_WIDTH'(BURST_MAX) : remaining;
      col_sum   = col_q + len_q;
      row_inc   = row_q + DIM_WIDTH'(1);
   end

   assign launch = ((state_q == S_IDLE) && i_wire_start) ||
                   ((state_q == S_DONE) && (i_wire_start || (i_wire_continuous && i_wire_frame_sync)));

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      addr_d    = addr_q;
      len_d     = len_q;
      error_d   = error_q;
      latch_cfg = 1'b0;
      if (i_wire_abort) begin
         state_d = S_IDLE;
         row_d   = '0;
         col_d   = '0;
         error_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (launch) begin
                  state_d   = S_CALC;
                  row_d     = '0;
                  col_d     = '0;
                  latch_cfg = 1'b1;
               end
            end
            S_CALC: begin
               if ((cw_q == '0) || (ch_q == '0)) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = calc_addr;
                  len_d   = calc_len;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (CW'(i_wire_fifo_free_count) >= CW'(len_q)) state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_STREAM;
            S_STREAM: begin
               // Error wins over a simultaneous done.
               if (i_wire_reader_error) begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end else if (i_wire_reader_done) begin
                  state_d = S_NEXT;
               end
            end
            S_NEXT: begin
               if (col_sum == cw_q) begin
                  col_d   = '0;
                  row_d   = row_inc;
                  state_d = (row_inc == ch_q) ? S_DONE : S_CALC;
               end else begin
                  col_d   = col_sum;
                  state_d = S_CALC;
               end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign done_entry = (state_d == S_DONE) && (state_q != S_DONE);

   always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
      if (i_wire_reset) begin
         state_q       <= S_IDLE;
         base_q        <= '0;
         stride_q      <= '0;
         vx_q          <= '0;
         vy_q          <= '0;
         cw_q          <= '0;
         ch_q          <= '0;
         row_q         <= '0;
         col_q         <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         error_q       <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         error_q      <= error_d;
         frame_done_q <= done_entry;
         if (done_entry) frame_count_q <= frame_count_q + 16'd1;
         if (latch_cfg) begin
            base_q   <= i_wire_image_address;
            stride_q <= i_wire_image_stride;
            vx_q     <= i_wire_view_x;
            vy_q     <= i_wire_view_y;
            cw_q     <= i_wire_clip_width;
            ch_q     <= i_wire_clip_height;
         end
      end
   end

   assign o_wire_reader_address = addr_q;
   assign o_wire_reader_length  = len_q;
   assign o_wire_reader_start   = (state_q == S_ISSUE);
   assign o_wire_busy           = (state_q == S_CALC) || (state_q == S_WAIT) || (state_q == S_ISSUE) ||
                                  (state_q == S_STREAM) || (state_q == S_NEXT);
   assign o_wire_frame_done     = frame_done_q;
   assign o_wire_error          = error_q;
   assign o_wire_state          = state_q;
   assign o_wire_row            = row_q;
   assign o_wire_frame_count    = frame_count_q;

endmodule

// File: tb/tb_painterengine_gpu_frame_streamer.sv
// Directed bench for the frame streamer: table of viewport geometries plus hand-written corner sequences.
module tb_painterengine_gpu_frame_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, abort, continuous, frame_sync;
   logic [31:0] base;
   logic [15:0] stride, vx, vy, cw, ch;
   logic [7:0]  free;
   logic [31:0] r_addr;
   logic [15:0] r_len;
   logic        r_start, r_done, r_error;
   logic        busy, frame_done, error;
   logic [2:0]  state;
   logic [15:0] row, frame_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] rq_addr[$];
   logic [15:0] rq_len[$];

   always #5 clk = ~clk;

   painterengine_gpu_frame_streamer #(
      .ADDR_WIDTH(32), .DIM_WIDTH(16), .BYTES_PER_PIXEL(4), .BURST_MAX(64), .FIFO_COUNT_WIDTH(8)
   ) dut (
      .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start), .i_wire_abort(abort),
      .i_wire_continuous(continuous), .i_wire_frame_sync(frame_sync),
      .i_wire_image_address(base), .i_wire_image_stride(stride),
      .i_wire_view_x(vx), .i_wire_view_y(vy), .i_wire_clip_width(cw), .i_wire_clip_height(ch),
      .i_wire_fifo_free_count(free),
      .o_wire_reader_address(r_addr), .o_wire_reader_length(r_len), .o_wire_reader_start(r_start),
      .i_wire_reader_done(r_done), .i_wire_reader_error(r_error),
      .o_wire_busy(busy), .o_wire_frame_done(frame_done), .o_wire_error(error),
      .o_wire_state(state), .o_wire_row(row), .o_wire_frame_count(frame_count)
   );

   always @(negedge clk) begin
      if (r_start === 1'b1) begin
         rq_addr.push_back(r_addr);
         rq_len.push_back(r_len);
      end
   end

   typedef struct {
      logic [31:0] base;
      logic [15:0] stride, vx, vy, cw, ch;
      int          exp_nreq;
      logic [31:0] exp_first_addr;
      logic [15:0] exp_first_len;
      logic [31:0] exp_last_addr;
      logic [15:0] exp_last_len;
   } vec_t;

   vec_t        vecs[7];
   logic [31:0] g_addr[6];
   logic [15:0] g_len[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_req();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         tick();
         if (r_start === 1'b1) ok = 1'b1;
      end
      check("wait_req_timeout", {63'd0, ok}, 64'd1);
   endtask

   task automatic wait_frame_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         tick();
         if (frame_done === 1'b1) ok = 1'b1;
      end
      check("wait_frame_done_timeout", {63'd0, ok}, 64'd1);
   endtask

   // Triggers a frame, answers each request with done 3 cycles later, and counts frame_done pulses.
   task automatic run_frame(input bit use_sync, output int ndone, output bit finished);
      int cd, post;
      cd = 0; post = -1; ndone = 0; finished = 1'b0;
      if (use_sync) frame_sync = 1'b1; else start = 1'b1;
      tick();
      frame_sync = 1'b0;
      start      = 1'b0;
      for (int c = 0; c < 4000 && post != 0; c++) begin
         tick();
         r_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) r_done = 1'b1;
         end
         if (r_start === 1'b1) cd = 3;
         if (frame_done === 1'b1) begin
            ndone++;
            finished = 1'b1;
            post = 5;
         end else if (post > 0) begin
            post--;
         end
      end
      r_done = 1'b0;
   endtask

   task automatic set_cfg(input logic [31:0] b, input logic [15:0] s, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] w, input logic [15:0] h);
      base = b; stride = s; vx = x; vy = y; cw = w; ch = h;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  ndone;
      bit  fin;
      int  bad;
      int  nreq0;

      vecs[0] = '{32'h1000,     16'd100, 16'd0, 16'd0, 16'd130, 16'd2, 6, 32'h1000,     16'd64, 32'h1390, 16'd2};
      vecs[1] = '{32'h0,        16'd100, 16'd3, 16'd1, 16'd10,  16'd1, 1, 32'h19C,      16'd10, 32'h19C,  16'd10};
      vecs[2] = '{32'h2000,     16'd64,  16'd0, 16'd2, 16'd64,  16'd3, 3, 32'h2200,     16'd64, 32'h2400, 16'd64};
      vecs[3] = '{32'hFFFFFFF0, 16'd16,  16'd4, 16'd1, 16'd1,   16'd1, 1, 32'h40,       16'd1,  32'h40,   16'd1};
      vecs[4] = '{32'h100,      16'd8,   16'd0, 16'd0, 16'd5,   16'd0, 0, 32'h0,        16'd0,  32'h0,    16'd0};
      vecs[5] = '{32'h100,      16'd8,   16'd0, 16'd0, 16'd0,   16'd3, 0, 32'h0,        16'd0,  32'h0,    16'd0};
      vecs[6] = '{32'h0,        16'd200, 16'd2, 16'd0, 16'd128, 16'd1, 2, 32'h8,        16'd64, 32'h108,  16'd64};
      g_addr  = '{32'h1000, 32'h1100, 32'h1200, 32'h1190, 32'h1290, 32'h1390};
      g_len   = '{16'd64, 16'd64, 16'd2, 16'd64, 16'd64, 16'd2};

      rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; frame_sync = 1'b0;
      r_done = 1'b0; r_error = 1'b0; free = 8'd128;
      set_cfg(32'h0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      tick(); tick();
      rst = 1'b0;
      tick();
      check("reset_state", {61'd0, state}, 64'd0);
      check("reset_flags", {60'd0, busy, r_start, frame_done, error}, 64'd0);
      check("reset_addr_len", {r_addr, r_len, 16'd0}, 64'd0);
      check("reset_row_count", {32'd0, row, frame_count}, 64'd0);

      for (int i = 0; i < 7; i++) begin
         set_cfg(vecs[i].base, vecs[i].stride, vecs[i].vx, vecs[i].vy, vecs[i].cw, vecs[i].ch);
         rq_addr.delete();
         rq_len.delete();
         run_frame(1'b0, ndone, fin);
         check($sformatf("v%0d_finished", i), {63'd0, fin}, 64'd1);
         check($sformatf("v%0d_frame_done_pulses", i), ndone, 1);
         check($sformatf("v%0d_nreq", i), rq_addr.size(), vecs[i].exp_nreq);
         check($sformatf("v%0d_frame_count", i), {48'd0, frame_count}, i + 1);
         check($sformatf("v%0d_state_done", i), {61'd0, state}, 64'd6);
         if (vecs[i].exp_nreq > 0 && rq_addr.size() > 0) begin
            check($sformatf("v%0d_first_addr", i), rq_addr[0], vecs[i].exp_first_addr);
            check($sformatf("v%0d_first_len", i), rq_len[0], vecs[i].exp_first_len);
            check($sformatf("v%0d_last_addr", i), rq_addr[rq_addr.size()-1], vecs[i].exp_last_addr);
            check($sformatf("v%0d_last_len", i), rq_len[rq_len.size()-1], vecs[i].exp_last_len);
         end
         if (i == 0 && rq_addr.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
               check($sformatf("geom_req%0d_addr", k), rq_addr[k], g_addr[k]);
               check($sformatf("geom_req%0d_len", k), rq_len[k], g_len[k]);
            end
         end
      end

      // frame_sync without continuous mode must not relaunch from DONE
      frame_sync = 1'b1; tick(); frame_sync = 1'b0;
      check("sync_ignored_noncont", {61'd0, state}, 64'd6);

      // Zero-height viewport: frame_done exactly 2 cycles after start, no request
      set_cfg(32'h0, 16'd100, 16'd0, 16'd0, 16'd8, 16'd0);
      nreq0 = rq_addr.size();
      launch();
      check("zero_h_calc", {62'd0, state == 3'd1, frame_done}, 64'd2);
      tick();
      check("zero_h_done_pulse", {62'd0, state == 3'd6, frame_done}, 64'd3);
      tick();
      check("zero_h_single_pulse", {63'd0, frame_done}, 64'd0);
      check("zero_h_no_request", rq_addr.size(), nreq0);

      // Back-pressure: stuck in WAIT while the FIFO cannot hold the burst
      set_cfg(32'h0, 16'd100, 16'd0, 16'd0, 16'd64, 16'd1);
      free = 8'd10;
      launch();
      tick();
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (state !== 3'd2 || r_start !== 1'b0) bad++;
      end
      check("bp_held_in_wait", bad, 0);
      free = 8'd64;
      check("bp_no_start_yet", {63'd0, r_start}, 64'd0);
      tick();
      check("bp_start_one_cycle_later", {63'd0, r_start}, 64'd1);
      check("bp_len", {48'd0, r_len}, 64'd64);
      tick();
      r_done = 1'b1; tick(); r_done = 1'b0;
      wait_frame_done();
      free = 8'd128;

      // Simultaneous done+error: error wins, sticky, start ignored, abort clears
      set_cfg(32'h0, 16'd100, 16'd0, 16'd0, 16'd10, 16'd1);
      launch();
      wait_req();
      tick();
      check("err_in_stream", {61'd0, state}, 64'd4);
      r_done = 1'b1; r_error = 1'b1;
      tick();
      r_done = 1'b0; r_error = 1'b0;
      check("err_state", {61'd0, state}, 64'd7);
      check("err_flag", {63'd0, error}, 64'd1);
      nreq0 = rq_addr.size();
      launch();
      for (int i = 0; i < 10; i++) tick();
      check("err_start_ignored", {61'd0, state}, 64'd7);
      check("err_no_requests", rq_addr.size(), nreq0);
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_from_err", {61'd0, state, error}, 64'd0);

      // Abort during STREAM, then a late done must be ignored
      set_cfg(32'h1000, 16'd100, 16'd0, 16'd0, 16'd130, 16'd2);
      launch();
      wait_req();
      tick();
      check("abort_in_stream", {61'd0, state}, 64'd4);
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_to_idle", {61'd0, state}, 64'd0);
      nreq0 = rq_addr.size();
      r_done = 1'b1; tick(); r_done = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("late_done_ignored", {44'd0, state, row, busy}, 64'd0);
      check("abort_no_requests", rq_addr.size(), nreq0);

      // Asynchronous reset in the middle of a burst
      launch();
      wait_req();
      tick();
      check("rst_in_stream", {61'd0, state}, 64'd4);
      #2 rst = 1'b1;
      #1;
      check("rst_async_state_flags", {56'd0, state, busy, r_start, frame_done, error}, 64'd0);
      check("rst_async_addr_len", {r_addr, r_len, 16'd0}, 64'd0);
      check("rst_async_row_count", {32'd0, row, frame_count}, 64'd0);
      tick();
      rst = 1'b0;
      nreq0 = rq_addr.size();
      for (int i = 0; i < 10; i++) tick();
      check("rst_stays_idle", {61'd0, state}, 64'd0);
      check("rst_no_requests", rq_addr.size(), nreq0);

      // Continuous mode: one start then two frame_sync relaunches
      continuous = 1'b1;
      set_cfg(32'h4000, 16'd10, 16'd2, 16'd3, 16'd1, 16'd1);
      rq_addr.delete();
      rq_len.delete();
      run_frame(1'b0, ndone, fin);
      check("cont_f1_done", ndone, 1);
      frame_sync = 1'b1; tick(); frame_sync = 1'b0;
      wait_req();
      tick();
      check("cont_f2_stream", {61'd0, state}, 64'd4);
      frame_sync = 1'b1; tick(); frame_sync = 1'b0;
      check("cont_sync_in_stream_ignored", {61'd0, state}, 64'd4);
      r_done = 1'b1; tick(); r_done = 1'b0;
      wait_frame_done();
      run_frame(1'b1, ndone, fin);
      check("cont_f3_done", ndone, 1);
      check("cont_frame_count", {48'd0, frame_count}, 64'd3);
      check("cont_nreq", rq_addr.size(), 3);
      for (int k = 0; k < 3 && k < rq_addr.size(); k++) begin
         check($sformatf("cont_req%0d_addr", k), rq_addr[k], 32'h4080);
         check($sformatf("cont_req%0d_len", k), rq_len[k], 16'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
